// File: rtl/xbar_tlul_mxn.sv
// NumHosts x NumDevices TL-UL crossbar: base/mask decode, per-device round-robin, single outstanding.
// Define XBAR_MXN_ERR_RESP_EN to answer unmapped requests with an internal error responder.
package xbar_tlul_pkg;
  localparam logic [2:0] OpGet       = 3'h4;
  localparam logic [2:0] OpAccessAck = 3'h0;
  localparam logic [2:0] OpAckData   = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module xbar_tlul_mxn
  import xbar_tlul_pkg::*;
#(
  parameter int          NumHosts   = 2,
  parameter int          NumDevices = 4,
  parameter logic [31:0] DevBase [NumDevices] = '{32'h0000_0000, 32'h0001_0000,
                                                  32'h0002_0000, 32'h0003_0000},
  parameter logic [31:0] DevMask [NumDevices] = '{default: 32'hFFFF_0000}
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  tl_h2d_t [NumHosts-1:0]     tl_h_i,
  output tl_d2h_t [NumHosts-1:0]     tl_h_o,
  output tl_h2d_t [NumDevices-1:0]   tl_d_o,
  input  tl_d2h_t [NumDevices-1:0]   tl_d_i
);
  localparam int TW = $clog2(NumDevices + 1);
  localparam int HW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
`ifdef XBAR_MXN_ERR_RESP_EN
  localparam logic [TW-1:0] ErrIdx = TW'(NumDevices);
  localparam logic [TW-1:0] DefIdx = TW'(NumDevices);
`else
  localparam logic [TW-1:0] DefIdx = TW'(NumDevices - 1);
`endif

  for (genvar j = 0; j < NumDevices; j++) begin : g_map_chk
    if ((DevBase[j] & ~DevMask[j]) != 32'h0) begin : g_bad
      $error("xbar_tlul_mxn: DevBase has bits outside DevMask");
    end
  end

  typedef enum logic {H_IDLE, H_WAIT} hst_e;
  typedef enum logic {D_FREE, D_BUSY} dst_e;

  hst_e [NumHosts-1:0]                  hst_q, hst_d;
  logic [NumHosts-1:0][TW-1:0]          tgt_q, tgt_d;
  dst_e [NumDevices-1:0]                dst_q, dst_d;
  logic [NumDevices-1:0][HW-1:0]        own_q, own_d, rr_q, rr_d, lockh_q, lockh_d;
  logic [NumDevices-1:0]                lock_q, lock_d;
  logic [NumHosts-1:0][TW-1:0]          dec;
  logic [NumDevices-1:0][NumHosts-1:0]  cand;
  logic [NumDevices-1:0]                win_vld;
  logic [NumDevices-1:0][HW-1:0]        win;
`ifdef XBAR_MXN_ERR_RESP_EN
  logic [NumHosts-1:0]                  err_vld_q, err_vld_d;
  logic [NumHosts-1:0][2:0]             err_op_q, err_op_d;
  logic [NumHosts-1:0][1:0]             err_size_q, err_size_d;
  logic [NumHosts-1:0][7:0]             err_src_q, err_src_d;
`endif

  // Descending scan so the lowest matching device index wins.
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      dec[h] = DefIdx;
      for (int j = NumDevices - 1; j >= 0; j--)
        if ((tl_h_i[h].a_address & DevMask[j]) == DevBase[j]) dec[h] = TW'(j);
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    cand    = '0;
    win_vld = '0;
    win     = '0;
    for (int j = 0; j < NumDevices; j++)
      for (int h = 0; h < NumHosts; h++)
        cand[j][h] = (hst_q[h] == H_IDLE) && tl_h_i[h].a_valid && (dec[h] == TW'(j));
    for (int j = 0; j < NumDevices; j++) begin
      if (!rst_i && dst_q[j] == D_FREE) begin
        // A stalled grant keeps its host so the request stays stable until accepted.
        if (lock_q[j] && cand[j][lockh_q[j]]) begin
          win_vld[j] = 1'b1;
          win[j]     = lockh_q[j];
        end else begin
          for (int k = 0; k < NumHosts; k++) begin
            idx = int'(rr_q[j]) + k;
            if (idx >= NumHosts) idx = idx - NumHosts;
            if (!win_vld[j] && cand[j][idx]) begin
              win_vld[j] = 1'b1;
              win[j]     = HW'(idx);
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NumDevices; j++) begin
      tl_d_o[j] = '0;
      if (win_vld[j]) tl_d_o[j] = tl_h_i[win[j]];
      tl_d_o[j].d_ready = (dst_q[j] == D_BUSY) ? tl_h_i[own_q[j]].d_ready : 1'b1;
    end
  end

  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      tl_h_o[h] = '0;
      if (!rst_i && hst_q[h] == H_IDLE) begin
`ifdef XBAR_MXN_ERR_RESP_EN
        if (dec[h] == ErrIdx) tl_h_o[h].a_ready = 1'b1;
`endif
        for (int j = 0; j < NumDevices; j++)
          if (dec[h] == TW'(j) && win_vld[j] && win[j] == HW'(h))
            tl_h_o[h].a_ready = tl_d_i[j].a_ready;
      end else if (!rst_i && hst_q[h] == H_WAIT) begin
        for (int j = 0; j < NumDevices; j++)
          if (tgt_q[h] == TW'(j) && dst_q[j] == D_BUSY && own_q[j] == HW'(h)) begin
            tl_h_o[h]         = tl_d_i[j];
            tl_h_o[h].a_ready = 1'b0;
          end
`ifdef XBAR_MXN_ERR_RESP_EN
        if (tgt_q[h] == ErrIdx) begin
          tl_h_o[h].d_valid  = err_vld_q[h];
          tl_h_o[h].d_opcode = err_op_q[h];
          tl_h_o[h].d_size   = err_size_q[h];
          tl_h_o[h].d_source = err_src_q[h];
          tl_h_o[h].d_data   = 32'hFFFF_FFFF;
          tl_h_o[h].d_error  = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    hst_d   = hst_q;
    tgt_d   = tgt_q;
    dst_d   = dst_q;
    own_d   = own_q;
    rr_d    = rr_q;
    lock_d  = '0;
    lockh_d = win;
`ifdef XBAR_MXN_ERR_RESP_EN
    err_vld_d  = err_vld_q;
    err_op_d   = err_op_q;
    err_size_d = err_size_q;
    err_src_d  = err_src_q;
`endif
    for (int h = 0; h < NumHosts; h++) begin
      if (hst_q[h] == H_IDLE && tl_h_i[h].a_valid && tl_h_o[h].a_ready) begin
        hst_d[h] = H_WAIT;
        tgt_d[h] = dec[h];
`ifdef XBAR_MXN_ERR_RESP_EN
        if (dec[h] == ErrIdx) begin
          err_vld_d[h]  = 1'b1;
          err_op_d[h]   = (tl_h_i[h].a_opcode == OpGet) ? OpAckData : OpAccessAck;
          err_size_d[h] = tl_h_i[h].a_size;
          err_src_d[h]  = tl_h_i[h].a_source;
        end
`endif
      end
      if (hst_q[h] == H_WAIT && tl_h_o[h].d_valid && tl_h_i[h].d_ready) begin
        hst_d[h] = H_IDLE;
`ifdef XBAR_MXN_ERR_RESP_EN
        err_vld_d[h] = 1'b0;
`endif
      end
    end
    for (int j = 0; j < NumDevices; j++) begin
      lock_d[j] = win_vld[j] && !tl_d_i[j].a_ready;
      if (win_vld[j] && tl_d_i[j].a_ready) begin
        dst_d[j] = D_BUSY;
        own_d[j] = win[j];
        rr_d[j]  = (win[j] == HW'(NumHosts - 1)) ? '0 : win[j] + 1'b1;
      end
      if (dst_q[j] == D_BUSY && tl_d_i[j].d_valid && tl_h_i[own_q[j]].d_ready)
        dst_d[j] = D_FREE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int h = 0; h < NumHosts; h++) hst_q[h] <= H_IDLE;
      for (int j = 0; j < NumDevices; j++) dst_q[j] <= D_FREE;
      tgt_q   <= '0;
      own_q   <= '0;
      rr_q    <= '0;
      lock_q  <= '0;
      lockh_q <= '0;
    end else begin
      hst_q   <= hst_d;
      tgt_q   <= tgt_d;
      dst_q   <= dst_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      lockh_q <= lockh_d;
    end
  end

`ifdef XBAR_MXN_ERR_RESP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_vld_q  <= '0;
      err_op_q   <= '0;
      err_size_q <= '0;
      err_src_q  <= '0;
    end else begin
      err_vld_q  <= err_vld_d;
      err_op_q   <= err_op_d;
      err_size_q <= err_size_d;
      err_src_q  <= err_src_d;
    end
  end
`endif
endmodule

// File: tb/tb_xbar_tlul_mxn.sv
// Directed bench for xbar_tlul_mxn (2 hosts, 4 devices); honours XBAR_MXN_ERR_RESP_EN.
module tb_xbar_tlul_mxn;
  import xbar_tlul_pkg::*;

  logic          clk, rst;
  tl_h2d_t [1:0] tl_h_i;
  tl_d2h_t [1:0] tl_h_o;
  tl_h2d_t [3:0] tl_d_o;
  tl_d2h_t [3:0] tl_d_i;

  logic [3:0]    dev_ardy;
  logic [31:0]   dev_data [4];
  logic [3:0]    dv_q;
  logic [7:0]    dsrc_q [4];
  logic [2:0]    dop_q [4];

  logic [7:0]    gl1[$], gl3[$];
  logic [15:0]   rlog[$];
  int            n_chk, n_fail;

  xbar_tlul_mxn dut (
    .clk_i (clk),
    .rst_i (rst),
    .tl_h_i(tl_h_i),
    .tl_h_o(tl_h_o),
    .tl_d_o(tl_d_o),
    .tl_d_i(tl_d_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Device models: accept when a_ready, answer the next cycle, hold until d_ready.
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (rst) dv_q[j] <= 1'b0;
      else if (dv_q[j] && tl_d_o[j].d_ready) dv_q[j] <= 1'b0;
      else if (tl_d_o[j].a_valid && dev_ardy[j]) begin
        dv_q[j]   <= 1'b1;
        dsrc_q[j] <= tl_d_o[j].a_source;
        dop_q[j]  <= (tl_d_o[j].a_opcode == OpGet) ? OpAckData : OpAccessAck;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      tl_d_i[j]          = '0;
      tl_d_i[j].a_ready  = dev_ardy[j];
      tl_d_i[j].d_valid  = dv_q[j];
      tl_d_i[j].d_opcode = dop_q[j];
      tl_d_i[j].d_source = dsrc_q[j];
      tl_d_i[j].d_size   = 2'd2;
      tl_d_i[j].d_data   = dev_data[j];
    end
  end

  always @(posedge clk) begin
    if (tl_d_o[3].a_valid && tl_d_i[3].a_ready) gl3.push_back(tl_d_o[3].a_source);
    if (tl_d_o[1].a_valid && tl_d_i[1].a_ready) gl1.push_back(tl_d_o[1].a_source);
    for (int h = 0; h < 2; h++)
      if (tl_h_o[h].d_valid && tl_h_i[h].d_ready) rlog.push_back({8'(h), tl_h_o[h].d_source});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] av_vec();
    for (int j = 0; j < 4; j++) av_vec[j] = tl_d_o[j].a_valid;
  endfunction

  function automatic logic [1:0] dv_vec();
    for (int h = 0; h < 2; h++) dv_vec[h] = tl_h_o[h].d_valid;
  endfunction

  task automatic host_req(input int h, input logic [31:0] addr, input logic [7:0] src);
    tl_h_i[h].a_valid   = 1'b1;
    tl_h_i[h].a_opcode  = OpGet;
    tl_h_i[h].a_size    = 2'd2;
    tl_h_i[h].a_mask    = 4'hF;
    tl_h_i[h].a_address = addr;
    tl_h_i[h].a_source  = src;
  endtask

  task automatic drain();
    for (int h = 0; h < 2; h++) begin
      tl_h_i[h].a_valid = 1'b0;
      tl_h_i[h].d_ready = 1'b1;
    end
    dev_ardy = 4'hF;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  exp_g [4];
    logic [15:0] exp_r [4];
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    tl_h_i   = '0;
    dev_ardy = 4'hF;
    for (int j = 0; j < 4; j++) dev_data[j] = 32'h0;
    tl_h_i[0].d_ready = 1'b1;
    tl_h_i[1].d_ready = 1'b1;

    // Reset held two cycles with requests pending.
    host_req(0, 32'h0000_0040, 8'h01);
    host_req(1, 32'h0001_0040, 8'h02);
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_aval", 32'(av_vec()), 32'h0);
      check("rst_dval", 32'(dv_vec()), 32'h0);
    end
    rst = 1'b0;
    #1 check("rst_release_aval", 32'(av_vec()), 32'h3);
    @(negedge clk);
    drain();

    // Single read to device 2.
    dev_data[2] = 32'hA5A5_0001;
    host_req(0, 32'h0002_0010, 8'h05);
    #1 check("rd_aval", 32'(av_vec()), 32'h4);
    check("rd_addr", tl_d_o[2].a_address, 32'h0002_0010);
    @(negedge clk);
    tl_h_i[0].a_valid = 1'b0;
    #1 check("rd_dval", 32'(tl_h_o[0].d_valid), 32'h1);
    check("rd_data", tl_h_o[0].d_data, 32'hA5A5_0001);
    check("rd_err", 32'(tl_h_o[0].d_error), 32'h0);
    check("rd_src", 32'(tl_h_o[0].d_source), 32'h05);
    check("rd_h1_dval", 32'(tl_h_o[1].d_valid), 32'h0);
    @(negedge clk); #1;
    check("rd_dval_done", 32'(tl_h_o[0].d_valid), 32'h0);
    drain();

    // Contention on device 3: grants alternate and responses route to their owner.
    gl3.delete();
    rlog.delete();
    host_req(0, 32'h0003_0000, 8'h10);
    host_req(1, 32'h0003_0004, 8'h21);
    repeat (8) @(negedge clk);
    tl_h_i[0].a_valid = 1'b0;
    tl_h_i[1].a_valid = 1'b0;
    exp_g = '{8'h10, 8'h21, 8'h10, 8'h21};
    exp_r = '{16'h0010, 16'h0121, 16'h0010, 16'h0121};
    check("ct_ngrant", 32'(gl3.size()), 32'd4);
    check("ct_nresp", 32'(rlog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("ct_grant", (i < gl3.size()) ? 32'(gl3[i]) : 32'hDEAD, 32'(exp_g[i]));
      check("ct_resp", (i < rlog.size()) ? 32'(rlog[i]) : 32'hDEAD, 32'(exp_r[i]));
    end
    drain();

    // Device 1 stalls a_ready for 5 cycles while both hosts request it.
    gl1.delete();
    dev_ardy[1] = 1'b0;
    host_req(0, 32'h0001_0000, 8'h30);
    host_req(1, 32'h0001_0008, 8'h41);
    repeat (5) begin
      #1;
      check("st_aval", 32'(tl_d_o[1].a_valid), 32'h1);
      check("st_src", 32'(tl_d_o[1].a_source), 32'h30);
      check("st_addr", tl_d_o[1].a_address, 32'h0001_0000);
      check("st_ardy", {30'h0, tl_h_o[1].a_ready, tl_h_o[0].a_ready}, 32'h0);
      @(negedge clk);
    end
    dev_ardy[1] = 1'b1;
    #1 check("st_ardy_rel", {30'h0, tl_h_o[1].a_ready, tl_h_o[0].a_ready}, 32'h1);
    @(negedge clk);
    check("st_ngrant", 32'(gl1.size()), 32'd1);
    check("st_winner", (gl1.size() > 0) ? 32'(gl1[0]) : 32'hDEAD, 32'h30);
    drain();

    // Unmapped access from host 1.
    host_req(1, 32'h0009_0000, 8'h52);
`ifdef XBAR_MXN_ERR_RESP_EN
    #1 check("um_ardy", 32'(tl_h_o[1].a_ready), 32'h1);
    check("um_aval", 32'(av_vec()), 32'h0);
    @(negedge clk);
    tl_h_i[1].a_valid = 1'b0;
    tl_h_i[1].d_ready = 1'b0;
    #1 check("um_dval", 32'(tl_h_o[1].d_valid), 32'h1);
    check("um_err", 32'(tl_h_o[1].d_error), 32'h1);
    check("um_data", tl_h_o[1].d_data, 32'hFFFF_FFFF);
    check("um_src", 32'(tl_h_o[1].d_source), 32'h52);
    check("um_op", 32'(tl_h_o[1].d_opcode), 32'(OpAckData));
    @(negedge clk); #1;
    check("um_hold_dval", 32'(tl_h_o[1].d_valid), 32'h1);
    check("um_hold_data", tl_h_o[1].d_data, 32'hFFFF_FFFF);
    tl_h_i[1].d_ready = 1'b1;
    @(negedge clk); #1;
    check("um_done", 32'(tl_h_o[1].d_valid), 32'h0);
`else
    #1 check("um_aval", 32'(av_vec()), 32'h8);
    check("um_addr", tl_d_o[3].a_address, 32'h0009_0000);
    @(negedge clk);
    tl_h_i[1].a_valid = 1'b0;
    #1 check("um_dval", 32'(tl_h_o[1].d_valid), 32'h1);
    check("um_src", 32'(tl_h_o[1].d_source), 32'h52);
`endif
    drain();

    // Host 0 back-pressures the device 0 response for 3 cycles.
    dev_data[0] = 32'h1234_5678;
    tl_h_i[0].d_ready = 1'b0;
    host_req(0, 32'h0000_0100, 8'h07);
    #1 check("bp_aval", 32'(av_vec()), 32'h1);
    @(negedge clk);
    tl_h_i[0].a_valid = 1'b0;
    host_req(1, 32'h0000_0200, 8'h61);
    repeat (3) begin
      #1;
      check("bp_dval", 32'(tl_h_o[0].d_valid), 32'h1);
      check("bp_data", tl_h_o[0].d_data, 32'h1234_5678);
      check("bp_src", 32'(tl_h_o[0].d_source), 32'h07);
      check("bp_no_grant", 32'(tl_d_o[0].a_valid), 32'h0);
      check("bp_h1_ardy", 32'(tl_h_o[1].a_ready), 32'h0);
      @(negedge clk);
    end
    tl_h_i[0].d_ready = 1'b1;
    #1 check("bp_dhs_aval", 32'(tl_d_o[0].a_valid), 32'h0);
    @(negedge clk); #1;
    check("bp_next_aval", 32'(tl_d_o[0].a_valid), 32'h1);
    check("bp_next_src", 32'(tl_d_o[0].a_source), 32'h61);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
